// File: rtl/tqvp_uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tqvp_uart_bus_bridge
// Description : UART command bridge acting as initiator on the TinyQV
//               peripheral bus. A frame CMD, ADDR[, DATA x1/2/4] received
//               from the UART becomes one bus read or write. The reply
//               (0xA5 ack plus read data, or 0xEE nak) goes back through
//               the UART transmitter one byte at a time.
//
// Ports       : clk, rst            clock, asynchronous active-high reset
//               rx_valid, rx_data   received byte strobe and value
//               tx_en, tx_data      transmit start pulse and byte
//               tx_busy             transmitter busy
//               bus_address         peripheral address (held when idle)
//               bus_wdata           write data, LSB-first assembled
//               bus_write_n         11 idle, 00/01/10 = 8/16/32-bit write
//               bus_read_n          11 idle, 00/01/10 = 8/16/32-bit read
//               bus_rdata           read data
//               bus_ready           read data valid
//               active              transaction in progress
//
// Revision    : 1.0  initial release
// ============================================================================
module tqvp_uart_bus_bridge #(
    parameter int FRAME_TIMEOUT = 640000,
    parameter int READ_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [5:0]  bus_address,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_write_n,
    output logic [1:0]  bus_read_n,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        active
);

    // Counter widths: the frame counter counts 0..FRAME_TIMEOUT-1 idle
    // cycles, the read counter counts 0..READ_TIMEOUT-1 strobe cycles.
    localparam int c_FT_W = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam int c_RT_W = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT) : 1;

    localparam logic [c_FT_W-1:0] c_FT_LAST = c_FT_W'(FRAME_TIMEOUT - 1);
    localparam logic [c_RT_W-1:0] c_RT_LAST = c_RT_W'(READ_TIMEOUT - 1);
    localparam logic [c_FT_W-1:0] c_FT_ONE  = c_FT_W'(1);
    localparam logic [c_RT_W-1:0] c_RT_ONE  = c_RT_W'(1);

    localparam logic [7:0] c_ACK     = 8'hA5;
    localparam logic [7:0] c_NAK     = 8'hEE;
    localparam logic [1:0] c_BUS_IDL = 2'b11;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ADDR   = 3'd1;
    localparam logic [2:0] c_ST_WDATA  = 3'd2;
    localparam logic [2:0] c_ST_BUS_WR = 3'd3;
    localparam logic [2:0] c_ST_BUS_RD = 3'd4;
    localparam logic [2:0] c_ST_RESP   = 3'd5;
    localparam logic [2:0] c_ST_TX_GAP = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_wr;
    logic [1:0]        r_sz;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_wbuf;
    logic [c_FT_W-1:0] r_frame_cnt;
    logic [c_RT_W-1:0] r_rd_cnt;
    // Response queue: byte 0 is sent first; up to ack + 4 data bytes.
    logic [39:0]       r_resp_q;
    logic [2:0]        r_resp_cnt;

    logic              w_cmd_ok;
    logic [1:0]        w_last_idx;
    logic              w_wr_last;
    logic              w_frame_expired;
    logic              w_rd_strobe;
    logic              w_wr_strobe;
    logic              w_rd_expired;
    logic [31:0]       w_wbuf_nxt;

    assign w_cmd_ok        = (rx_data[6:2] == 5'd0) && (rx_data[1:0] != 2'b11);
    assign w_last_idx      = (r_sz == 2'b00) ? 2'd0 : (r_sz == 2'b01) ? 2'd1 : 2'd3;
    assign w_wr_last       = (r_byte_idx == w_last_idx);
    assign w_frame_expired = !rx_valid && (r_frame_cnt == c_FT_LAST);
    assign w_rd_strobe     = (bus_read_n != c_BUS_IDL);
    assign w_wr_strobe     = (bus_write_n != c_BUS_IDL);
    assign w_rd_expired    = (r_rd_cnt == c_RT_LAST);

    // Write buffer with the incoming byte merged into its lane, so the last
    // byte and the earlier ones reach bus_wdata in the same update.
    always_comb begin
        w_wbuf_nxt = r_wbuf;
        w_wbuf_nxt[{r_byte_idx, 3'b000} +: 8] = rx_data;
    end

    // Next-state logic. BUS_WR and BUS_RD spend their first cycle with the
    // strobe still idle so address/data are settled one cycle before it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_valid) begin
                    w_state_nxt = w_cmd_ok ? c_ST_ADDR : c_ST_RESP;
                end
            end
            c_ST_ADDR: begin
                if (rx_valid) begin
                    w_state_nxt = r_wr ? c_ST_WDATA : c_ST_BUS_RD;
                end else if (w_frame_expired) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WDATA: begin
                if (rx_valid) begin
                    if (w_wr_last) begin
                        w_state_nxt = c_ST_BUS_WR;
                    end
                end else if (w_frame_expired) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_BUS_WR: begin
                if (w_wr_strobe) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_BUS_RD: begin
                if (w_rd_strobe && (bus_ready || w_rd_expired)) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (r_resp_cnt == 3'd0) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (!tx_busy) begin
                    w_state_nxt = c_ST_TX_GAP;
                end
            end
            c_ST_TX_GAP: begin
                w_state_nxt = c_ST_RESP;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_en       <= 1'b0;
            tx_data     <= 8'h00;
            bus_address <= 6'd0;
            bus_wdata   <= 32'd0;
            bus_write_n <= c_BUS_IDL;
            bus_read_n  <= c_BUS_IDL;
            active      <= 1'b0;
            r_wr        <= 1'b0;
            r_sz        <= 2'b00;
            r_byte_idx  <= 2'd0;
            r_wbuf      <= 32'd0;
            r_frame_cnt <= '0;
            r_rd_cnt    <= '0;
            r_resp_q    <= 40'd0;
            r_resp_cnt  <= 3'd0;
        end else begin
            tx_en <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (rx_valid) begin
                        active      <= 1'b1;
                        r_wr        <= rx_data[7];
                        r_sz        <= rx_data[1:0];
                        r_frame_cnt <= '0;
                        if (!w_cmd_ok) begin
                            r_resp_q   <= {32'd0, c_NAK};
                            r_resp_cnt <= 3'd1;
                        end
                    end
                end
                c_ST_ADDR, c_ST_WDATA: begin
                    if (rx_valid) begin
                        r_frame_cnt <= '0;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + c_FT_ONE;
                    end
                    if (w_frame_expired) begin
                        active <= 1'b0;
                    end
                    if (rx_valid && (r_state == c_ST_ADDR)) begin
                        bus_address <= rx_data[5:0];
                        r_byte_idx  <= 2'd0;
                        r_wbuf      <= 32'd0;
                    end
                    if (rx_valid && (r_state == c_ST_WDATA)) begin
                        r_wbuf     <= w_wbuf_nxt;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_wr_last) begin
                            bus_wdata <= w_wbuf_nxt;
                        end
                    end
                end
                c_ST_BUS_WR: begin
                    if (!w_wr_strobe) begin
                        bus_write_n <= r_sz;
                    end else begin
                        bus_write_n <= c_BUS_IDL;
                        r_resp_q    <= {32'd0, c_ACK};
                        r_resp_cnt  <= 3'd1;
                    end
                end
                c_ST_BUS_RD: begin
                    if (!w_rd_strobe) begin
                        bus_read_n <= r_sz;
                        r_rd_cnt   <= '0;
                    end else if (bus_ready) begin
                        bus_read_n <= c_BUS_IDL;
                        r_resp_q   <= {bus_rdata, c_ACK};
                        r_resp_cnt <= (r_sz == 2'b00) ? 3'd2 :
                                      (r_sz == 2'b01) ? 3'd3 : 3'd5;
                    end else if (w_rd_expired) begin
                        bus_read_n <= c_BUS_IDL;
                        r_resp_q   <= {32'd0, c_NAK};
                        r_resp_cnt <= 3'd1;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + c_RT_ONE;
                    end
                end
                c_ST_RESP: begin
                    if (r_resp_cnt == 3'd0) begin
                        active <= 1'b0;
                    end else if (!tx_busy) begin
                        tx_en      <= 1'b1;
                        tx_data    <= r_resp_q[7:0];
                        r_resp_q   <= {8'd0, r_resp_q[39:8]};
                        r_resp_cnt <= r_resp_cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
